axis_rr_arbiter: RTL and testbench

//  Round-robin arbiter sharing one AXI-Stream sink (e.g. FIFO write port) between NUM_SRC AXIS sources.

---
 rtl/axis_rr_arbiter_pkg.sv | 11 +
 rtl/axis_rr_arbiter_if.sv | 27 ++
 rtl/axis_rr_arbiter_rr_pick.sv | 31 +++
 rtl/axis_rr_arbiter.sv | 107 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
package axis_arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

  // Index width for n sources, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_arbiter_if.sv
// Bundle of the NUM_SRC source streams and the single arbitrated sink stream.
interface axis_rr_arbiter_if
  import axis_arb_pkg::*;
#(
  parameter int VAR_WIDTH = 16,
  parameter int NUM_SRC   = 4,
  parameter int ID_W      = id_w(NUM_SRC)
);
  // Source i data sits at bits [i*VAR_WIDTH +: VAR_WIDTH].
  logic [NUM_SRC-1:0][VAR_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]                s_axis_tvalid;
  logic [NUM_SRC-1:0]                s_axis_tready;
  logic [VAR_WIDTH-1:0]              m_axis_tdata;
  logic [ID_W-1:0]                   m_axis_tid;
  logic                              m_axis_tvalid;
  logic                              m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tid, m_axis_tvalid
  );
endinterface

// File: rtl/axis_rr_arbiter_rr_pick.sv
// Combinational rotating priority pick: first set req starting at ptr, wrapping mod N.
module rr_pick
  import axis_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = id_w(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_any
);

  int idx;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[W'(idx)]) begin
        gnt_any = 1'b1;
        gnt_idx = W'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin burst arbiter: NUM_SRC AXIS sources onto one registered AXIS sink,
// each beat tagged with the index of the source that produced it.
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int VAR_WIDTH = 16,
  parameter int NUM_SRC   = 4,
  parameter int BURST_LEN = 4
) (
  input logic            clk,
  input logic            rst,
  axis_rr_arbiter_if.slave bus
);

  localparam int ID_W  = id_w(NUM_SRC);
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [VAR_WIDTH-1:0] tdata_q, tdata_d;
  logic [ID_W-1:0]      tid_q, tid_d;
  logic                 tvalid_q, tvalid_d;

  logic [ID_W-1:0]      pick_idx, next_ptr;
  logic                 pick_any, out_free, grant_vld, accept, last_beat;
  logic [NUM_SRC-1:0]   s_tready;

  rr_pick #(.N(NUM_SRC), .W(ID_W)) u_pick (
    .req     (bus.s_axis_tvalid),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign out_free  = !tvalid_q || bus.m_axis_tready;
  assign grant_vld = bus.s_axis_tvalid[grant_q];
  assign accept    = (state_q == GRANT) && grant_vld && out_free;
  assign last_beat = (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign next_ptr  = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    tdata_d    = tdata_q;
    tid_d      = tid_q;
    tvalid_d   = tvalid_q;
    s_tready   = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        s_tready[grant_q] = out_free;
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        // A bubble only releases the grant when the sink could have taken a beat.
        if ((accept && last_beat) || (out_free && !grant_vld)) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase

    if (out_free) begin
      tvalid_d = accept;
      if (accept) begin
        tdata_d = bus.s_axis_tdata[grant_q];
        tid_d   = grant_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
      tdata_q    <= '0;
      tid_q      <= '0;
      tvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      tdata_q    <= tdata_d;
      tid_q      <= tid_d;
      tvalid_q   <= tvalid_d;
    end
  end

  assign bus.s_axis_tready = s_tready;
  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tid    = tid_q;
  assign bus.m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: per-source beat queues drive the inputs,
// expected output beats are queued up front and popped on every sink handshake.
module tb_axis_rr_arbiter;
  import axis_arb_pkg::*;

  localparam int VW = 16;
  localparam int NS = 4;
  localparam int BL = 4;
  localparam int IW = id_w(NS);

  typedef struct packed {
    logic [VW-1:0] data;
    logic [IW-1:0] tid;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.VAR_WIDTH(VW), .NUM_SRC(NS)) bus ();

  axis_rr_arbiter #(.VAR_WIDTH(VW), .NUM_SRC(NS), .BURST_LEN(BL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  beat_t         exp_q[$];
  logic [VW-1:0] src_q[NS][$];
  logic [NS-1:0] src_en;
  logic          mrdy;
  logic          stall_chk;
  int            hs_cnt[NS];
  int            hs_cyc[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            out_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.m_axis_tready = mrdy;
    for (int i = 0; i < NS; i++) begin
      bus.s_axis_tvalid[i] = src_en[i] && (src_q[i].size() > 0);
      bus.s_axis_tdata[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic push_src(input int s, input int base, input int n);
    for (int k = 0; k < n; k++) src_q[s].push_back(VW'(base + k));
  endtask

  task automatic exp_push(input int s, input int base, input int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = VW'(base + k);
      b.tid  = IW'(s);
      exp_q.push_back(b);
    end
  endtask

  // One clock: observe at negedge, advance source queues just after posedge.
  task automatic cycle();
    logic [NS-1:0] hs;
    beat_t e;
    @(negedge clk);
    hs = bus.s_axis_tvalid & bus.s_axis_tready;
    if (stall_chk && exp_q.size() > 0) begin
      chk("stall_vld", bus.m_axis_tvalid, 1);
      chk("stall_data", bus.m_axis_tdata, exp_q[0].data);
      chk("stall_tid", bus.m_axis_tid, exp_q[0].tid);
      chk("stall_srdy", bus.s_axis_tready, 0);
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      out_cnt++;
      chk("exp_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tdata", bus.m_axis_tdata, e.data);
        chk("tid", bus.m_axis_tid, e.tid);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        void'(src_q[i].pop_front());
        hs_cnt[i]++;
        if (i == 2) hs_cyc.push_back(cyc);
      end
    end
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      hs_cnt[i] = 0;
    end
    exp_q.delete();
    hs_cyc.delete();
    src_en    = '1;
    mrdy      = 1'b1;
    stall_chk = 1'b0;
    out_cnt   = 0;
    drive();
    @(posedge clk);
    #1;
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tdata", bus.m_axis_tdata, 0);
    chk("rst_tid", bus.m_axis_tid, 0);
    chk("rst_srdy", bus.s_axis_tready, 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int left;
    rst = 1'b1;
    mrdy = 1'b1;
    src_en = '1;
    stall_chk = 1'b0;
    do_reset();

    // Reset mid-burst with a beat sitting in the output register.
    push_src(0, 'h1000, 4);
    exp_push(0, 'h1000, 4);
    drive();
    repeat (3) cycle();
    chk("pre_rst_vld", bus.m_axis_tvalid, 1);
    do_reset();
    cycle();
    chk("post_rst_idle_srdy", bus.s_axis_tready, 0);
    chk("post_rst_idle_vld", bus.m_axis_tvalid, 0);

    // Single source, ten beats: re-granted to itself with a bubble per burst.
    do_reset();
    push_src(2, 'h0A00, 10);
    exp_push(2, 'h0A00, 10);
    drive();
    drain(100);
    chk("t2_hs_count", hs_cyc.size(), 10);
    if (hs_cyc.size() >= 9) begin
      chk("t2_gap_b1", hs_cyc[1] - hs_cyc[0], 1);
      chk("t2_gap_b4", hs_cyc[4] - hs_cyc[3], 2);
      chk("t2_gap_b8", hs_cyc[8] - hs_cyc[7], 2);
    end

    // All four sources valid: strict rotation in bursts of BL.
    do_reset();
    push_src(0, 'h3000, 8);
    push_src(1, 'h3100, 4);
    push_src(2, 'h3200, 4);
    push_src(3, 'h3300, 4);
    exp_push(0, 'h3000, 4);
    exp_push(1, 'h3100, 4);
    exp_push(2, 'h3200, 4);
    exp_push(3, 'h3300, 4);
    exp_push(0, 'h3004, 4);
    drive();
    drain(200);
    left = 0;
    for (int i = 0; i < NS; i++) left += src_q[i].size();
    chk("t3_left", left, 0);

    // Pointer moved to 2 by a one-beat src1 burst; src3 must win next.
    do_reset();
    push_src(1, 'h4000, 1);
    exp_push(1, 'h4000, 1);
    drive();
    drain(50);
    repeat (3) cycle();
    push_src(1, 'h4100, 4);
    push_src(3, 'h4300, 4);
    exp_push(3, 'h4300, 4);
    exp_push(1, 'h4100, 4);
    drive();
    drain(100);

    // Sink backpressure for five cycles mid-burst.
    do_reset();
    push_src(0, 'h5000, 8);
    exp_push(0, 'h5000, 8);
    drive();
    n = 0;
    while (out_cnt < 2 && n < 50) begin
      cycle();
      n++;
    end
    chk("t5_reach", out_cnt, 2);
    mrdy = 1'b0;
    drive();
    stall_chk = 1'b1;
    repeat (5) cycle();
    stall_chk = 1'b0;
    mrdy = 1'b1;
    drive();
    drain(100);

    // Src0 bubbles after two beats: grant passes to src1, src0 finishes later.
    do_reset();
    push_src(0, 'h6000, 3);
    push_src(1, 'h6100, 4);
    exp_push(0, 'h6000, 2);
    exp_push(1, 'h6100, 4);
    exp_push(0, 'h6002, 1);
    drive();
    n = 0;
    while (hs_cnt[0] < 2 && n < 50) begin
      cycle();
      n++;
    end
    chk("t6_reach", hs_cnt[0], 2);
    src_en[0] = 1'b0;
    drive();
    repeat (3) cycle();
    src_en[0] = 1'b1;
    drive();
    drain(100);
    chk("t6_src0_done", src_q[0].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
